// File: rtl/median_stream_ctrl.sv
// median_stream_ctrl: frame-level controller for a 3x3 median filter over a
// raster pixel stream. Pixels shift into a (2*W+3)-deep window register; the
// nine taps feed median_3x3 (3-cycle latency) while a matching side pipeline
// carries valid/border/last/centre. Border pixels pass through unchanged,
// interior pixels get the 3x3 median. The output frame has W*H pixels.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   i_start  frame start pulse, honoured only in IDLE
//   i_valid  input pixel valid
//   i_pixel  input pixel, raster order
//   i_ready  controller accepts a pixel (FILL and RUN only)
//   o_valid  output pixel valid (one-cycle qualifier)
//   o_pixel  filtered pixel, raster order
//   o_last   marks the last pixel of the frame, with o_valid
//   o_busy   high from start acceptance until o_last has been output

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

// median_3x3: 3-stage pipelined median of nine pixels.
// Stage 1 sorts each row, stage 2 takes max-of-mins / median-of-medians /
// min-of-maxes, stage 3 takes the median of those three.
//   i_p0..i_p8  window pixels (order is irrelevant to the result)
//   o_median    registered median, 3 cycles after the inputs
module median_3x3 #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic [PW-1:0] i_p0,
  input  logic [PW-1:0] i_p1,
  input  logic [PW-1:0] i_p2,
  input  logic [PW-1:0] i_p3,
  input  logic [PW-1:0] i_p4,
  input  logic [PW-1:0] i_p5,
  input  logic [PW-1:0] i_p6,
  input  logic [PW-1:0] i_p7,
  input  logic [PW-1:0] i_p8,
  output logic [PW-1:0] o_median
);
  typedef logic [PW-1:0] px_t;

  function automatic px_t mn(px_t a, px_t b);
    return (a < b) ? a : b;
  endfunction
  function automatic px_t mx(px_t a, px_t b);
    return (a > b) ? a : b;
  endfunction
  function automatic px_t md(px_t a, px_t b, px_t c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction

  logic [8:0][PW-1:0] p;
  logic [2:0][PW-1:0] lo, mi, hi;
  px_t s2_lo, s2_mi, s2_hi;

  assign p = {i_p8, i_p7, i_p6, i_p5, i_p4, i_p3, i_p2, i_p1, i_p0};

  always_ff @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      lo[r] <= mn(mn(p[3*r], p[3*r+1]), p[3*r+2]);
      mi[r] <= md(p[3*r], p[3*r+1], p[3*r+2]);
      hi[r] <= mx(mx(p[3*r], p[3*r+1]), p[3*r+2]);
    end
    s2_lo    <= mx(mx(lo[0], lo[1]), lo[2]);
    s2_mi    <= md(mi[0], mi[1], mi[2]);
    s2_hi    <= mn(mn(hi[0], hi[1]), hi[2]);
    o_median <= md(s2_lo, s2_mi, s2_hi);
  end
endmodule

module median_stream_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_start,
  input  logic                    i_valid,
  input  logic [`PIXEL_WIDTH-1:0] i_pixel,
  output logic                    i_ready,
  output logic                    o_valid,
  output logic [`PIXEL_WIDTH-1:0] o_pixel,
  output logic                    o_last,
  output logic                    o_busy
);
  localparam int PW     = `PIXEL_WIDTH;
  localparam int W      = IMG_WIDTH;
  localparam int H      = IMG_HEIGHT;
  localparam int DEPTH  = 2*W + 3;
  localparam int NPIX   = W*H;
  localparam int CW     = $clog2(NPIX);   // in_cnt spans 0..NPIX-1
  localparam int FW     = $clog2(W + 1);  // fl_cnt spans 0..W
  localparam int XW     = $clog2(W);
  localparam int YW     = $clog2(H);
  localparam int STAGES = 3;              // median_3x3 latency

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t                   state;
  logic [CW-1:0]            in_cnt;
  logic [FW-1:0]            fl_cnt;
  logic [XW-1:0]            out_col;
  logic [YW-1:0]            out_row;
  logic [DEPTH-1:0][PW-1:0] win;       // win[d] = pixel pushed d pushes ago
  logic [STAGES:0]          vld_pipe, brd_pipe, lst_pipe;
  logic [STAGES:1][PW-1:0]  ctr_pipe;
  logic [PW-1:0]            med;
  logic                     accept, push, emit, at_border, at_last;
  logic [PW-1:0]            push_data;

  assign i_ready   = (state == FILL) || (state == RUN);
  assign accept    = i_ready & i_valid;
  assign push      = accept | (state == FLUSH);
  assign emit      = ((state == RUN) & i_valid) | (state == FLUSH);
  assign push_data = (state == FLUSH) ? '0 : i_pixel;

  assign at_border = (out_row == '0) || (out_row == YW'(H-1)) ||
                     (out_col == '0) || (out_col == XW'(W-1));
  assign at_last   = (out_row == YW'(H-1)) && (out_col == XW'(W-1));

  // o_valid is the last stage of the side pipeline, so busy holds through
  // the o_last cycle and drops right after it.
  assign o_busy = (state != IDLE) || (|vld_pipe) || o_valid;

  // Window and centre delay carry no reset: their contents are qualified by
  // the valid pipeline.
  always_ff @(posedge clk) begin
    if (push) win <= {win[DEPTH-2:0], push_data};
    ctr_pipe <= {ctr_pipe[STAGES-1:1], win[W+1]};
  end

  median_3x3 #(.PW(PW)) u_med (
    .clk      (clk),
    .i_p0     (win[2*W+2]),
    .i_p1     (win[2*W+1]),
    .i_p2     (win[2*W]),
    .i_p3     (win[W+2]),
    .i_p4     (win[W+1]),
    .i_p5     (win[W]),
    .i_p6     (win[2]),
    .i_p7     (win[1]),
    .i_p8     (win[0]),
    .o_median (med)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_cnt   <= '0;
      fl_cnt   <= '0;
      out_col  <= '0;
      out_row  <= '0;
      vld_pipe <= '0;
      brd_pipe <= '0;
      lst_pipe <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_pixel  <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state  <= FILL;
          in_cnt <= '0;
          fl_cnt <= '0;
        end
        // First W+1 pushes only prime the window; the (W+1)th moves to RUN.
        FILL: if (accept) begin
          in_cnt <= in_cnt + 1'b1;
          if (in_cnt == CW'(W)) state <= RUN;
        end
        RUN: if (accept) begin
          in_cnt <= in_cnt + 1'b1;
          if (in_cnt == CW'(NPIX-1)) begin
            state  <= FLUSH;
            fl_cnt <= '0;
          end
        end
        // W+1 zero pushes to drain the centres still inside the window.
        FLUSH: begin
          fl_cnt <= fl_cnt + 1'b1;
          if (fl_cnt == FW'(W)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (emit) begin
        if (out_col == XW'(W-1)) begin
          out_col <= '0;
          out_row <= (out_row == YW'(H-1)) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end

      vld_pipe <= {vld_pipe[STAGES-1:0], emit};
      brd_pipe <= {brd_pipe[STAGES-1:0], at_border};
      lst_pipe <= {lst_pipe[STAGES-1:0], at_last};

      o_valid <= vld_pipe[STAGES];
      o_last  <= vld_pipe[STAGES] & lst_pipe[STAGES];
      if (vld_pipe[STAGES])
        o_pixel <= brd_pipe[STAGES] ? ctr_pipe[STAGES] : med;
    end
  end
endmodule

// File: tb/tb_median_stream_ctrl.sv
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module tb_median_stream_ctrl;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int N  = W*H;
  localparam int PW = `PIXEL_WIDTH;

  logic          clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_valid = 1'b0;
  logic [PW-1:0] i_pixel = '0;
  logic          i_ready, o_valid, o_last, o_busy;
  logic [PW-1:0] o_pixel;

  int checks = 0, failures = 0;
  int cyc = 0;
  int last_seen = -100;

  typedef struct { int px; bit last; } exp_t;
  exp_t exp_q[$];
  int   cyc_q[$];
  int   frame[N];
  exp_t m_e;
  int   m_ec;

  median_stream_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_valid (i_valid),
    .i_pixel (i_pixel),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_pixel (o_pixel),
    .o_last  (o_last),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;
  // cyc == C at a negedge means the next rising edge is edge C.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: median of the 3x3 neighbourhood by sorting the nine values.
  function automatic int med9(int r, int c);
    int q[$];
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        q.push_back(frame[(r+dr)*W + c + dc]);
    q.sort();
    return q[4];
  endfunction

  task automatic gen_frame(input int pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (pat)
          0:       frame[r*W+c] = 50;
          1:       frame[r*W+c] = (r == 0 && c == 0) ? 200 : (r == 1 && c == 1) ? 255 : 10;
          2:       frame[r*W+c] = r*W + c;
          default: frame[r*W+c] = int'($urandom_range(0, 255));
        endcase
  endtask

  task automatic push_expected();
    exp_t e;
    for (int n = 0; n < N; n++) begin
      int r, c;
      r = n / W;
      c = n % W;
      e.px   = (r == 0 || r == H-1 || c == 0 || c == W-1) ? frame[n] : med9(r, c);
      e.last = (n == N-1);
      exp_q.push_back(e);
    end
  endtask

  // Called positioned at a negedge; returns positioned at a negedge.
  task automatic run_frame(input int pat, input bit gaps, input bit poke,
                           input int abort, input bit b2b);
    int idx = 0, guard = 0, c_last = 0;
    gen_frame(pat);
    push_expected();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("ready_after_start", i_ready, 1);
    chk("busy_after_start", o_busy, 1);
    while (idx < N && guard < 1000) begin
      guard++;
      i_start = 1'b0;
      if (abort >= 0 && idx == abort) break;
      if (gaps && $urandom_range(0, 2) == 0) i_valid = 1'b0;
      else if (i_ready) begin
        i_valid = 1'b1;
        i_pixel = PW'(frame[idx]);
        // Input idx presents centre idx-(W+1); its output follows edge+4.
        if (idx >= W+1) cyc_q.push_back(cyc + 5);
        if (poke && idx == N/2) i_start = 1'b1;
        c_last = cyc;
        idx++;
      end else i_valid = 1'b0;
      @(negedge clk);
    end
    i_valid = 1'b0;
    i_start = 1'b0;

    if (abort >= 0) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      cyc_q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("valid_after_reset", o_valid, 0);
      chk("ready_after_reset", i_ready, 0);
      chk("busy_after_reset", o_busy, 0);
      repeat (12) @(negedge clk);
      return;
    end

    chk("inputs_accepted", idx, N);
    chk("ready_low_in_flush", i_ready, 0);
    for (int j = 1; j <= W+1; j++) cyc_q.push_back(c_last + j + 5);
    if (poke) begin
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end

    if (b2b) begin
      while (cyc < c_last + W + 2) @(negedge clk);
      chk("idle_ready_low", i_ready, 0);
      return;
    end

    guard = 0;
    while (o_busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_falls_after_last", cyc, last_seen + 1);
    chk("outputs_remaining", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: pixel value, last flag and arrival cycle per output.
  always @(negedge clk) begin
    if (o_valid) begin
      if (exp_q.size() == 0 || cyc_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got pixel %0d with no expected entry (cycle %0d)", o_pixel, cyc);
      end else begin
        m_e  = exp_q.pop_front();
        m_ec = cyc_q.pop_front();
        chk("out_pixel", o_pixel, m_e.px);
        chk("out_last", o_last, m_e.last);
        chk("out_cycle", cyc, m_ec);
      end
      if (o_last) begin
        chk("busy_with_last", o_busy, 1);
        last_seen = cyc;
      end
    end else begin
      chk("last_without_valid", o_last, 0);
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", i_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_pixel", o_pixel, 0);
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 1'b0, 1'b0, -1, 1'b0);  // constant 50
    run_frame(1, 1'b0, 1'b0, -1, 1'b0);  // impulse at border and interior
    run_frame(2, 1'b0, 1'b0, -1, 1'b0);  // ramp, back-to-back inputs
    run_frame(2, 1'b1, 1'b0, -1, 1'b0);  // ramp with input gaps
    run_frame(3, 1'b1, 1'b1, -1, 1'b0);  // random, start pokes in RUN/FLUSH
    run_frame(3, 1'b0, 1'b0, 12, 1'b0);  // reset mid-RUN
    run_frame(3, 1'b1, 1'b0, -1, 1'b0);  // fresh frame after reset
    run_frame(3, 1'b0, 1'b0, -1, 1'b1);  // frame A, next start on first IDLE
    run_frame(3, 1'b0, 1'b1, -1, 1'b0);  // frame B overlapping A's drain

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
